mips_multicycle_main_controller: RTL

- Main control FSM for the multicycle MIPS datapath; it is the producer side of the 2-bit ALUOp interface.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the ALUOp codes consumed by the ALU control decoder: 00 add, 01 subtract, 10 decode funct, 11 or.
- Also drives all datapath select and write-enable lines, and waits on a memory-ready handshake.

---
 rtl/mips_multicycle_main_controller.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_main_controller.sv
// mips_multicycle_main_controller
//
// Main control FSM for the multicycle MIPS datapath. It walks each
// instruction through fetch, decode, execute, memory and writeback. It
// produces the 2-bit ALUOP code for the ALU control decoder
// (00 add, 01 subtract, 10 decode funct, 11 or). It also drives every
// datapath select and write-enable line.
//
// Optional feature: define MIPS_CTRL_BNE_EN to decode bne (6'b000101) into
// the BRANCHNE state. Without the macro, bne is treated as an illegal opcode.
//
// Memory handshake: mem_ready is a completion strobe. The controller holds a
// request (FETCH read, MEMRD read, MEMWR write with MemWrite high) stable for
// as long as it stays in that state. The cycle in which mem_ready is sampled
// high is the cycle the access completes. The FSM then leaves the state on
// the next rising edge. No request is ever withdrawn except by reset.
//
// Reset gating: while rst_n is low, every write/load strobe (MemWrite,
// IRWrite, RegWrite, pc_en) and illegal_op is forced low. An aborted
// instruction therefore cannot commit anything on the reset edge. The select
// lines keep following the registered state.

module mips_multicycle_main_controller #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_ORI   = 6'b001101,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOP,
  output logic [1:0] PCSrc,
  output logic       pc_en,
  output logic       illegal_op,
  output logic [3:0] state
);

`ifdef MIPS_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE = 6'b000101;
`endif

  // ALUOP codes understood by the downstream ALU control decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  // ALU B operand selects.
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH  = 2'b11;

  // Next-PC selects.
  localparam logic [1:0] PC_ALURES   = 2'b00;
  localparam logic [1:0] PC_ALUOUT   = 2'b01;
  localparam logic [1:0] PC_JUMP     = 2'b10;

  // Binary state encoding. The numeric values are visible on the debug port.
  // BRANCHNE is decoded only when bne support is compiled in. Otherwise its
  // encoding behaves like any other unused encoding.
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEX   = 4'd9,
    ORIEX    = 4'd10,
    IMMWB    = 4'd11,
    JUMP     = 4'd12,
    BRANCHNE = 4'd13
  } state_t;

  state_t state_q;
  state_t next_state;

  // Ungated versions of the strobes that reset must suppress.
  logic raw_memwrite;
  logic raw_irwrite;
  logic raw_regwrite;
  logic raw_pc_en;
  logic raw_illegal;

  // State register: a synchronous reset returns the machine to FETCH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= next_state;
    end
  end

  // Next-state and output decode from the registered state.
  // Every output defaults to 0, so each state lists only what it asserts.
  always_comb begin
    next_state   = FETCH;
    IorD         = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = SRCB_REG;
    ALUOP        = ALUOP_ADD;
    PCSrc        = PC_ALURES;
    raw_memwrite = 1'b0;
    raw_irwrite  = 1'b0;
    raw_regwrite = 1'b0;
    raw_pc_en    = 1'b0;
    raw_illegal  = 1'b0;

    case (state_q)
      // Instruction read at PC. The PC+4 update and the IR load both
      // happen in the cycle the memory completes.
      FETCH: begin
        IorD        = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_FOUR;
        ALUOP       = ALUOP_ADD;
        PCSrc       = PC_ALURES;
        raw_irwrite = mem_ready;
        raw_pc_en   = mem_ready;
        next_state  = mem_ready ? DECODE : FETCH;
      end

      // The ALU precomputes PC + (SignImm << 2) so that BRANCH can
      // take it from ALUOut without an extra cycle.
      DECODE: begin
        ALUSrcA = 1'b0;
        ALUSrcB = SRCB_IMMSH;
        ALUOP   = ALUOP_ADD;
        case (opcode)
          OP_LW,
          OP_SW:    next_state = MEMADR;
          OP_RTYPE: next_state = EXECUTE;
          OP_BEQ:   next_state = BRANCH;
          OP_ADDI:  next_state = ADDIEX;
          OP_ORI:   next_state = ORIEX;
          OP_J:     next_state = JUMP;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE:   next_state = BRANCHNE;
`endif
          default: begin
            next_state  = FETCH;
            raw_illegal = 1'b1;
          end
        endcase
      end

      // Effective address = A + SignImm. Only lw and sw reach this
      // state. Any other opcode here falls back to FETCH defensively.
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOP   = ALUOP_ADD;
        if (opcode == OP_LW) begin
          next_state = MEMRD;
        end else if (opcode == OP_SW) begin
          next_state = MEMWR;
        end else begin
          next_state = FETCH;
        end
      end

      // Data read at ALUOut. The state is held until the memory completes.
      MEMRD: begin
        IorD       = 1'b1;
        next_state = mem_ready ? MEMWB : MEMRD;
      end

      // Load writeback into rt from the data register.
      MEMWB: begin
        RegDst       = 1'b0;
        MemtoReg     = 1'b1;
        raw_regwrite = 1'b1;
        next_state   = FETCH;
      end

      // Store. The write strobe stays high until the memory accepts it.
      MEMWR: begin
        IorD         = 1'b1;
        raw_memwrite = 1'b1;
        next_state   = mem_ready ? FETCH : MEMWR;
      end

      // R-type operation. The ALU control decodes funct.
      EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_REG;
        ALUOP      = ALUOP_FUNCT;
        next_state = ALUWB;
      end

      // R-type writeback into rd.
      ALUWB: begin
        RegDst       = 1'b1;
        MemtoReg     = 1'b0;
        raw_regwrite = 1'b1;
        next_state   = FETCH;
      end

      // beq compare via subtract. The branch target comes from ALUOut.
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_REG;
        ALUOP      = ALUOP_SUB;
        PCSrc      = PC_ALUOUT;
        raw_pc_en  = zero;
        next_state = FETCH;
      end

      // addi: A + SignImm.
      ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        ALUOP      = ALUOP_ADD;
        next_state = IMMWB;
      end

      // ori: A | imm. The datapath supplies the zero-extended immediate
      // on the same operand select.
      ORIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        ALUOP      = ALUOP_OR;
        next_state = IMMWB;
      end

      // Immediate writeback into rt.
      IMMWB: begin
        RegDst       = 1'b0;
        MemtoReg     = 1'b0;
        raw_regwrite = 1'b1;
        next_state   = FETCH;
      end

      // Jump: load the PC from the jump target.
      JUMP: begin
        PCSrc      = PC_JUMP;
        raw_pc_en  = 1'b1;
        next_state = FETCH;
      end

`ifdef MIPS_CTRL_BNE_EN
      // bne: same datapath setup as beq, with the taken condition inverted.
      BRANCHNE: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_REG;
        ALUOP      = ALUOP_SUB;
        PCSrc      = PC_ALUOUT;
        raw_pc_en  = ~zero;
        next_state = FETCH;
      end
`endif

      // Unused encodings: drive nothing and recover to FETCH.
      default: begin
        next_state = FETCH;
      end
    endcase
  end

  // Suppress all commits and the illegal pulse while reset is asserted.
  assign MemWrite   = rst_n & raw_memwrite;
  assign IRWrite    = rst_n & raw_irwrite;
  assign RegWrite   = rst_n & raw_regwrite;
  assign pc_en      = rst_n & raw_pc_en;
  assign illegal_op = rst_n & raw_illegal;

  assign state = state_q;

endmodule
